// File: rtl/add_result_checker.sv
// Self-checking monitor for a pipelined WIDTH-bit adder: predicts each sum at operand
// accept, compares against res_i LATENCY cycles later, and latches an end-of-run verdict.
module add_result_checker #(
   parameter int WIDTH   = 8,
   parameter int LATENCY = 1,
   parameter int CNT_W   = 16
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             start_i,
   input  logic [CNT_W-1:0] num_pairs_i,
   input  logic             op_valid_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [WIDTH-1:0] res_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             pass_o,
   output logic [CNT_W-1:0] checked_o,
   output logic [CNT_W-1:0] err_cnt_o,
   output logic [CNT_W-1:0] first_err_idx_o,
   output logic [WIDTH-1:0] first_err_exp_o,
   output logic [WIDTH-1:0] first_err_got_o
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t                        state;
   logic [CNT_W-1:0]              num_q;
   logic [CNT_W-1:0]              acc_cnt;
   logic [LATENCY-1:0]            dl_vld;
   logic [LATENCY-1:0][WIDTH-1:0] dl_exp;
   logic [LATENCY-1:0][CNT_W-1:0] dl_idx;

   logic             accept, cmp, mism;
   logic [WIDTH-1:0] sum;

   // Carry-out is intentionally dropped: the adder under test is WIDTH bits wide.
   assign sum    = a_i + b_i;
   assign accept = (state == S_RUN) && op_valid_i && (acc_cnt < num_q);
   assign cmp    = dl_vld[LATENCY-1] && ((state == S_RUN) || (state == S_DRAIN));
   assign mism   = cmp && (res_i != dl_exp[LATENCY-1]);

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state           <= S_IDLE;
         num_q           <= '0;
         acc_cnt         <= '0;
         dl_vld          <= '0;
         dl_exp          <= '0;
         dl_idx          <= '0;
         busy_o          <= 1'b0;
         done_o          <= 1'b0;
         pass_o          <= 1'b0;
         checked_o       <= '0;
         err_cnt_o       <= '0;
         first_err_idx_o <= '0;
         first_err_exp_o <= '0;
         first_err_got_o <= '0;
      end else begin
         dl_vld[0] <= accept;
         dl_exp[0] <= sum;
         dl_idx[0] <= acc_cnt;
         for (int i = 1; i < LATENCY; i++) begin
            dl_vld[i] <= dl_vld[i-1];
            dl_exp[i] <= dl_exp[i-1];
            dl_idx[i] <= dl_idx[i-1];
         end

         if (accept) acc_cnt <= acc_cnt + 1'b1;

         if (cmp) begin
            checked_o <= checked_o + 1'b1;
            if (mism) begin
               if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + 1'b1;
               if (err_cnt_o == '0) begin
                  first_err_idx_o <= dl_idx[LATENCY-1];
                  first_err_exp_o <= dl_exp[LATENCY-1];
                  first_err_got_o <= res_i;
               end
            end
         end

         case (state)
            S_IDLE, S_DONE: begin
               if (start_i) begin
                  num_q           <= num_pairs_i;
                  acc_cnt         <= '0;
                  dl_vld          <= '0;
                  checked_o       <= '0;
                  err_cnt_o       <= '0;
                  first_err_idx_o <= '0;
                  first_err_exp_o <= '0;
                  first_err_got_o <= '0;
                  if (num_pairs_i == '0) begin
                     state  <= S_DONE;
                     busy_o <= 1'b0;
                     done_o <= 1'b1;
                     pass_o <= 1'b1;
                  end else begin
                     state  <= S_RUN;
                     busy_o <= 1'b1;
                     done_o <= 1'b0;
                     pass_o <= 1'b0;
                  end
               end
            end
            S_RUN: begin
               if (accept && (acc_cnt == num_q - 1'b1)) state <= S_DRAIN;
            end
            S_DRAIN: begin
               // checked_o is final here, so the verdict is taken one cycle after the last compare.
               if (checked_o == num_q) begin
                  state  <= S_DONE;
                  busy_o <= 1'b0;
                  done_o <= 1'b1;
                  pass_o <= (err_cnt_o == '0);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_add_result_checker.sv
// Directed bench: one checker at LATENCY=1 and one at LATENCY=3 share operands,
// each fed by a behavioural adder with selectable faults.
module tb_add_result_checker;

   localparam int W = 8;
   localparam int C = 16;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [C-1:0] num;
   logic         opv;
   logic [W-1:0] a, b;
   logic         flip;
   int           mode;     // 0 = correct adder, 1 = saturating (wrong) adder
   logic [W-1:0] stg [3];
   logic [W-1:0] res1, res3;

   logic         busy1, done1, pass1, busy3, done3, pass3;
   logic [C-1:0] chk1, err1, idx1, chk3, err3, idx3;
   logic [W-1:0] exp1, got1, exp3, got3;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   // Behavioural adder: result of an operand driven in cycle t is visible after edge t+k-1.
   always_ff @(posedge clk) begin
      logic [W:0] full;
      full = {1'b0, a} + {1'b0, b};
      if (mode == 1 && full[W]) stg[0] <= '1;
      else                      stg[0] <= full[W-1:0] ^ {{(W-1){1'b0}}, flip};
      stg[1] <= stg[0];
      stg[2] <= stg[1];
   end
   assign res1 = stg[0];
   assign res3 = stg[2];

   add_result_checker #(.WIDTH(W), .LATENCY(1), .CNT_W(C)) dut1 (
      .clk_i(clk), .reset_i(rst_n), .start_i(start), .num_pairs_i(num),
      .op_valid_i(opv), .a_i(a), .b_i(b), .res_i(res1),
      .busy_o(busy1), .done_o(done1), .pass_o(pass1), .checked_o(chk1),
      .err_cnt_o(err1), .first_err_idx_o(idx1), .first_err_exp_o(exp1),
      .first_err_got_o(got1));

   add_result_checker #(.WIDTH(W), .LATENCY(3), .CNT_W(C)) dut3 (
      .clk_i(clk), .reset_i(rst_n), .start_i(start), .num_pairs_i(num),
      .op_valid_i(opv), .a_i(a), .b_i(b), .res_i(res3),
      .busy_o(busy3), .done_o(done3), .pass_o(pass3), .checked_o(chk3),
      .err_cnt_o(err3), .first_err_idx_o(idx3), .first_err_exp_o(exp3),
      .first_err_got_o(got3));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input int n);
      num   = C'(n);
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic pair(input int x, input int y, input logic f);
      opv  = 1'b1;
      a    = W'(x);
      b    = W'(y);
      flip = f;
      step();
      opv  = 1'b0;
      flip = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (!(done1 && done3) && n < 100) begin
         step();
         n++;
      end
      chk({tag, "_done"}, {31'b0, done1 && done3}, 32'd1);
   endtask

   task automatic scen1_pairs();
      pair(1, 2, 1'b0);
      pair(3, 4, 1'b0);
      pair(200, 100, 1'b0);
      pair(255, 1, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; num = '0; opv = 1'b0;
      a = '0; b = '0; flip = 1'b0; mode = 0;
      step(); step();
      chk("rst_busy", {31'b0, busy1}, 0);
      chk("rst_done", {31'b0, done1}, 0);
      chk("rst_pass", {31'b0, pass1}, 0);
      chk("rst_checked", {16'b0, chk1}, 0);
      chk("rst_err", {16'b0, err1}, 0);
      chk("rst_idx", {16'b0, idx1}, 0);
      rst_n = 1'b1;
      step();

      // 1: correct adder, both latencies
      do_start(4);
      chk("s1_busy", {31'b0, busy1}, 1);
      chk("s1_notdone", {31'b0, done1}, 0);
      scen1_pairs();
      wait_done("s1");
      chk("s1_pass", {31'b0, pass1}, 1);
      chk("s1_busy_low", {31'b0, busy1}, 0);
      chk("s1_checked", {16'b0, chk1}, 4);
      chk("s1_err", {16'b0, err1}, 0);
      chk("s6_l3_pass", {31'b0, pass3}, 1);
      chk("s6_l3_checked", {16'b0, chk3}, 4);
      chk("s6_l3_err", {16'b0, err3}, 0);

      // 2: adder saturates instead of wrapping
      mode = 1;
      do_start(4);
      scen1_pairs();
      wait_done("s2");
      mode = 0;
      chk("s2_err", {16'b0, err1}, 2);
      chk("s2_idx", {16'b0, idx1}, 2);
      chk("s2_exp", {24'b0, exp1}, 44);
      chk("s2_got", {24'b0, got1}, 255);
      chk("s2_pass", {31'b0, pass1}, 0);
      chk("s2_l3_idx", {16'b0, idx3}, 2);

      // 3: single bit-0 fault on pair 5 of 10 (35+16=51 -> 50)
      do_start(10);
      for (int i = 0; i < 10; i++) pair(i * 7, i * 3 + 1, i == 5);
      wait_done("s3");
      chk("s3_err", {16'b0, err1}, 1);
      chk("s3_idx", {16'b0, idx1}, 5);
      chk("s3_exp", {24'b0, exp1}, 51);
      chk("s3_got", {24'b0, got1}, 50);
      chk("s3_pass", {31'b0, pass1}, 0);
      chk("s3_checked", {16'b0, chk1}, 10);

      // 4: num=3, valid pattern 1,0,0,1,1,1,1,1 (six valid cycles offered)
      do_start(3);
      pair(10, 20, 1'b0);
      step(); step();
      for (int i = 0; i < 5; i++) pair(i + 40, i + 1, 1'b0);
      wait_done("s4");
      chk("s4_checked", {16'b0, chk1}, 3);
      chk("s4_pass", {31'b0, pass1}, 1);
      chk("s4_l3_checked", {16'b0, chk3}, 3);

      // 5: reset mid-run after 2 of 8 pairs
      do_start(8);
      pair(5, 6, 1'b0);
      pair(7, 8, 1'b0);
      rst_n = 1'b0;
      #2;
      chk("s5_busy", {31'b0, busy1}, 0);
      chk("s5_done", {31'b0, done1}, 0);
      chk("s5_checked", {16'b0, chk1}, 0);
      chk("s5_l3_busy", {31'b0, busy3}, 0);
      step();
      rst_n = 1'b1;
      step();
      chk("s5_idle_done", {31'b0, done1}, 0);
      do_start(2);
      pair(100, 27, 1'b0);
      pair(128, 128, 1'b0);
      wait_done("s5b");
      chk("s5b_pass", {31'b0, pass1}, 1);
      chk("s5b_checked", {16'b0, chk1}, 2);

      // 6: zero-pair run completes immediately
      do_start(0);
      chk("s6_done", {31'b0, done1}, 1);
      chk("s6_pass", {31'b0, pass1}, 1);
      chk("s6_busy", {31'b0, busy1}, 0);
      chk("s6_l3_done", {31'b0, done3}, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
